// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, bus/data widths, beat counts,
// and the men2reg encoding that the writeback mux decodes.
package mem_stage_pkg;

  localparam int DATA_W     = 48;
  localparam int SCAL_W     = 32;
  localparam int BEAT_W     = 16;
  localparam int ADDR_W     = 32;
  localparam int VEC_BEATS  = DATA_W / BEAT_W;
  localparam int SCAL_BEATS = SCAL_W / BEAT_W;
  localparam int K_W        = 2;

  // Writeback source select carried through this stage untouched.
  localparam logic [1:0] MEN2REG_ALU = 2'd0;
  localparam logic [1:0] MEN2REG_MEM = 2'd1;
  localparam logic [1:0] MEN2REG_IMM = 2'd2;
  localparam logic [1:0] MEN2REG_PC  = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [K_W-1:0] last_beat(input logic vec);
    return vec ? K_W'(VEC_BEATS - 1) : K_W'(SCAL_BEATS - 1);
  endfunction

endpackage

// File: rtl/vec_beat_packer.sv
// Little-endian beat slicer/inserter: beat k lives at data[BEAT_W*k +: BEAT_W].
// Purely combinational; the caller owns the assembly buffer register.
module vec_beat_packer #(
  parameter int DATA_W = 48,
  parameter int BEAT_W = 16,
  parameter int K_W    = 2
) (
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_buf,
  input  logic [BEAT_W-1:0] i_rbeat,
  input  logic [K_W-1:0]    i_k,
  output logic [BEAT_W-1:0] o_wbeat,
  output logic [DATA_W-1:0] o_buf_next
);

  localparam int NB = DATA_W / BEAT_W;

  always_comb begin
    o_wbeat    = '0;
    o_buf_next = i_buf;
    for (int b = 0; b < NB; b++) begin
      if (i_k == K_W'(b)) begin
        o_wbeat                          = i_wdata[b*BEAT_W +: BEAT_W];
        o_buf_next[b*BEAT_W +: BEAT_W]   = i_rbeat;
      end
    end
  end

endmodule

// File: rtl/mem_stage_access.sv
// Memory stage: scalar/vector loads and stores as 16b beats on a single-outstanding req/gnt/rvalid bus.
// Optional macro MEM_MISALIGN_TRAP_EN traps odd base addresses instead of aligning them down.
module mem_stage_access
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic              in_vec,
  input  logic [ADDR_W-1:0] in_aluRes,
  input  logic [DATA_W-1:0] in_aluResV,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_reg_write,
  input  logic [1:0]        in_men2reg,
  input  logic [31:0]       in_signImm,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_vd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_aluRes,
  output logic [DATA_W-1:0] out_aluResV,
  output logic              out_reg_write,
  output logic [1:0]        out_men2reg,
  output logic [31:0]       out_signImm,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_vd,
  output logic              stall,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
  output state_t            dbg_state
);

  localparam logic [DATA_W-1:0] SCAL_MASK = {{(DATA_W-SCAL_W){1'b0}}, {SCAL_W{1'b1}}};

  // Handshake: a beat is transferred on any cycle with mem_req & mem_gnt; read data returns
  // on a later cycle with mem_rvalid and only one beat is ever outstanding.
  state_t            r_state;
  logic [K_W-1:0]    r_k;
  logic [DATA_W-1:0] r_buf;
  logic              r_is_wr;
  logic              r_vec;
  logic [ADDR_W-1:0] r_aluRes;
  logic [DATA_W-1:0] r_aluResV;
  logic [DATA_W-1:0] r_wdata;
  logic              r_reg_write;
  logic [1:0]        r_men2reg;
  logic [31:0]       r_signImm;
  logic [4:0]        r_rd;
  logic [4:0]        r_vd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              r_misalign;
`endif

  logic              w_mem_op;
  logic              w_last;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;
  logic [BEAT_W-1:0] w_wbeat;
  logic [DATA_W-1:0] w_buf_next;

  assign w_mem_op = in_mem_rd | in_mem_wr;
  assign w_last   = (r_k == last_beat(r_vec));
  // Odd bases are aligned down; in the trap build they never reach the bus.
  assign w_base   = {r_aluRes[ADDR_W-1:1], 1'b0};
  assign w_addr   = w_base + ADDR_W'({r_k, 1'b0});

  vec_beat_packer #(
    .DATA_W (DATA_W),
    .BEAT_W (BEAT_W),
    .K_W    (K_W)
  ) u_packer (
    .i_wdata    (r_wdata),
    .i_buf      (r_buf),
    .i_rbeat    (mem_rdata),
    .i_k        (r_k),
    .o_wbeat    (w_wbeat),
    .o_buf_next (w_buf_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_buf       <= '0;
      r_is_wr     <= 1'b0;
      r_vec       <= 1'b0;
      r_aluRes    <= '0;
      r_aluResV   <= '0;
      r_wdata     <= '0;
      r_reg_write <= 1'b0;
      r_men2reg   <= '0;
      r_signImm   <= '0;
      r_rd        <= '0;
      r_vd        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && w_mem_op) begin
            r_k         <= '0;
            r_buf       <= '0;
            r_is_wr     <= in_mem_wr;
            r_vec       <= in_vec;
            r_aluRes    <= in_aluRes;
            r_aluResV   <= in_aluResV;
            r_wdata     <= in_wdata;
            r_reg_write <= in_reg_write;
            r_men2reg   <= in_men2reg;
            r_signImm   <= in_signImm;
            r_rd        <= in_rd;
            r_vd        <= in_vd;
`ifdef MEM_MISALIGN_TRAP_EN
            if (in_aluRes[0]) begin
              r_misalign <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state    <= in_mem_wr ? WR : RD;
            end
`else
            r_state     <= in_mem_wr ? WR : RD;
`endif
          end
        end
        WR: begin
          if (mem_gnt) begin
            if (w_last) begin
              r_k     <= '0;
              r_state <= DONE;
            end else begin
              r_k     <= r_k + 1'b1;
            end
          end
        end
        RD: begin
          if (mem_gnt) r_state <= RWAIT;
        end
        RWAIT: begin
          if (mem_rvalid) begin
            r_buf <= w_buf_next;
            if (w_last) begin
              r_k     <= '0;
              r_state <= DONE;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= RD;
            end
          end
        end
        DONE: begin
          r_k        <= '0;
          r_state    <= IDLE;
`ifdef MEM_MISALIGN_TRAP_EN
          r_misalign <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The IDLE passthrough is combinational, so it is gated by rst to keep outputs low in reset.
  always_comb begin
    out_valid     = 1'b0;
    out_data      = '0;
    out_aluRes    = '0;
    out_aluResV   = '0;
    out_reg_write = 1'b0;
    out_men2reg   = '0;
    out_signImm   = '0;
    out_rd        = '0;
    out_vd        = '0;
    stall         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_err  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (rst && in_valid) begin
          if (w_mem_op) begin
            stall = 1'b1;
          end else begin
            out_valid     = 1'b1;
            out_aluRes    = in_aluRes;
            out_aluResV   = in_aluResV;
            out_reg_write = in_reg_write;
            out_men2reg   = in_men2reg;
            out_signImm   = in_signImm;
            out_rd        = in_rd;
            out_vd        = in_vd;
          end
        end
      end
      WR: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_addr;
        mem_wdata = w_wbeat;
      end
      RD: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = w_addr;
      end
      RWAIT: stall = 1'b1;
      DONE: begin
        out_valid     = 1'b1;
        out_data      = r_is_wr ? '0 : (r_vec ? r_buf : (r_buf & SCAL_MASK));
        out_aluRes    = r_aluRes;
        out_aluResV   = r_aluResV;
        out_reg_write = r_reg_write;
        out_men2reg   = r_men2reg;
        out_signImm   = r_signImm;
        out_rd        = r_rd;
        out_vd        = r_vd;
`ifdef MEM_MISALIGN_TRAP_EN
        if (r_misalign) begin
          out_reg_write = 1'b0;
          out_data      = '0;
          misalign_err  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: passthrough, vector store, delayed-grant scalar load,
// reset mid-access and odd-address load (behaviour depends on MEM_MISALIGN_TRAP_EN).
module tb_mem_stage_access;
  import mem_stage_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid, in_mem_rd, in_mem_wr, in_vec;
  logic [ADDR_W-1:0] in_aluRes;
  logic [DATA_W-1:0] in_aluResV, in_wdata;
  logic              in_reg_write;
  logic [1:0]        in_men2reg;
  logic [31:0]       in_signImm;
  logic [4:0]        in_rd, in_vd;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_aluRes;
  logic [DATA_W-1:0] out_aluResV;
  logic              out_reg_write;
  logic [1:0]        out_men2reg;
  logic [31:0]       out_signImm;
  logic [4:0]        out_rd, out_vd;
  logic              stall;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [BEAT_W-1:0] mem_rdata;
  state_t            dbg_state;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_access dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_mem_rd     (in_mem_rd),
    .in_mem_wr     (in_mem_wr),
    .in_vec        (in_vec),
    .in_aluRes     (in_aluRes),
    .in_aluResV    (in_aluResV),
    .in_wdata      (in_wdata),
    .in_reg_write  (in_reg_write),
    .in_men2reg    (in_men2reg),
    .in_signImm    (in_signImm),
    .in_rd         (in_rd),
    .in_vd         (in_vd),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_aluRes    (out_aluRes),
    .out_aluResV   (out_aluResV),
    .out_reg_write (out_reg_write),
    .out_men2reg   (out_men2reg),
    .out_signImm   (out_signImm),
    .out_rd        (out_rd),
    .out_vd        (out_vd),
    .stall         (stall),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_err  (misalign_err),
`endif
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_mem_rd = 0; in_mem_wr = 0; in_vec = 0;
    in_aluRes = '0; in_aluResV = '0; in_wdata = '0;
    in_reg_write = 0; in_men2reg = '0; in_signImm = '0; in_rd = '0; in_vd = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic present_op(input logic rd, input logic wr, input logic vec,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    in_valid     = 1; in_mem_rd = rd; in_mem_wr = wr; in_vec = vec;
    in_aluRes    = addr;
    in_wdata     = wdata;
    in_aluResV   = 48'h0123_4567_89AB;
    in_reg_write = rd;
    in_men2reg   = rd ? MEN2REG_MEM : MEN2REG_ALU;
    in_signImm   = 32'hFFFF_FFF0;
    in_rd        = 5'd7;
    in_vd        = 5'd9;
  endtask

  // One read beat: gnt held off for 'delay' cycles (with stray rvalid that must be ignored).
  task automatic load_beat(input logic [ADDR_W-1:0] addr, input logic [BEAT_W-1:0] data, input int delay);
    for (int d = 0; d < delay; d++) begin
      cyc(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 16'hDEAD;
      smp();
      chk("rd_wait_req", mem_req, 1);
      chk("rd_wait_stall", stall, 1);
      chk("rd_wait_addr", mem_addr, addr);
    end
    cyc(); mem_rvalid = 0; mem_gnt = 1;
    smp();
    chk("rd_req", mem_req, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, addr);
    cyc(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = data;
    smp();
    chk("rwait_req", mem_req, 0);
    chk("rwait_stall", stall, 1);
    chk("rwait_state", dbg_state, RWAIT);
  endtask

  logic [ADDR_W-1:0] st_addr [3];
  logic [BEAT_W-1:0] st_data [3];

  initial begin
    st_addr[0] = 32'h100; st_addr[1] = 32'h102; st_addr[2] = 32'h104;
    st_data[0] = 16'hCCCC; st_data[1] = 16'hBBBB; st_data[2] = 16'hAAAA;

    rst = 0;
    idle_inputs();
    in_valid = 1; in_aluRes = 32'h55;
    smp();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_out_alu", out_aluRes, 0);
    in_valid = 0; in_aluRes = '0;
    #1 rst = 1;

    // ALU passthrough, back-to-back
    cyc();
    in_valid = 1; in_aluRes = 32'h1234; in_aluResV = 48'hFEDC_BA98_7654;
    in_reg_write = 1; in_men2reg = MEN2REG_ALU; in_signImm = 32'h0000_0042; in_rd = 5'd3; in_vd = 5'd4;
    smp();
    chk("alu_valid", out_valid, 1);
    chk("alu_res", out_aluRes, 32'h1234);
    chk("alu_resv", out_aluResV, 48'hFEDC_BA98_7654);
    chk("alu_rd", out_rd, 5'd3);
    chk("alu_imm", out_signImm, 32'h42);
    chk("alu_stall", stall, 0);
    chk("alu_req", mem_req, 0);
    cyc(); in_aluRes = 32'h5678;
    smp();
    chk("alu2_res", out_aluRes, 32'h5678);
    cyc(); in_valid = 0;
    smp();
    chk("alu_off_valid", out_valid, 0);

    // Vector store, gnt always 1
    cyc();
    present_op(0, 1, 1, 32'h100, 48'hAAAA_BBBB_CCCC);
    mem_gnt = 1;
    smp();
    chk("vst_cap_stall", stall, 1);
    chk("vst_cap_req", mem_req, 0);
    chk("vst_cap_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); smp();
      chk("vst_req", mem_req, 1);
      chk("vst_we", mem_we, 1);
      chk("vst_addr", mem_addr, st_addr[k]);
      chk("vst_wdata", mem_wdata, st_data[k]);
      chk("vst_stall", stall, 1);
    end
    cyc(); smp();
    chk("vst_done_valid", out_valid, 1);
    chk("vst_done_stall", stall, 0);
    chk("vst_done_req", mem_req, 0);
    chk("vst_done_data", out_data, 0);
    chk("vst_done_alu", out_aluRes, 32'h100);
    chk("vst_done_rd", out_rd, 5'd7);
    chk("vst_done_resv", out_aluResV, 48'h0123_4567_89AB);
    cyc(); idle_inputs();
    smp();
    chk("vst_after_valid", out_valid, 0);
    chk("vst_after_state", dbg_state, IDLE);

    // Scalar load, gnt delayed 2 cycles
    cyc();
    present_op(1, 0, 0, 32'h40, '0);
    smp();
    chk("sld_cap_stall", stall, 1);
    load_beat(32'h40, 16'h5678, 2);
    load_beat(32'h42, 16'h1234, 2);
    cyc(); mem_rvalid = 0;
    smp();
    chk("sld_done_valid", out_valid, 1);
    chk("sld_done_data", out_data, 48'h0000_1234_5678);
    chk("sld_done_stall", stall, 0);
    chk("sld_done_rw", out_reg_write, 1);
    chk("sld_done_m2r", out_men2reg, MEN2REG_MEM);
    chk("sld_done_alu", out_aluRes, 32'h40);
    cyc(); idle_inputs();
    smp();
    chk("sld_after_valid", out_valid, 0);

    // Vector load, reset during second RWAIT
    cyc();
    present_op(1, 0, 1, 32'h200, '0);
    smp();
    load_beat(32'h200, 16'h1111, 0);
    cyc(); mem_rvalid = 0; mem_gnt = 1;
    smp();
    chk("vld_b1_addr", mem_addr, 32'h202);
    cyc(); mem_gnt = 0;
    smp();
    chk("vld_rwait2", dbg_state, RWAIT);
    #1 rst = 0;
    #1;
    chk("vld_rst_stall", stall, 0);
    chk("vld_rst_req", mem_req, 0);
    chk("vld_rst_valid", out_valid, 0);
    chk("vld_rst_state", dbg_state, IDLE);
    chk("vld_rst_data", out_data, 0);
    idle_inputs();
    cyc(); mem_rvalid = 1; mem_rdata = 16'h2222;
    smp();
    chk("vld_inrst_req", mem_req, 0);
    #1 rst = 1;
    cyc(); mem_rvalid = 0;
    smp();
    chk("vld_post_req", mem_req, 0);
    chk("vld_post_stall", stall, 0);
    chk("vld_post_state", dbg_state, IDLE);
    cyc();
    in_valid = 1; in_aluRes = 32'hBEEF; in_reg_write = 1;
    smp();
    chk("post_alu_valid", out_valid, 1);
    chk("post_alu_res", out_aluRes, 32'hBEEF);
    chk("post_alu_stall", stall, 0);
    cyc(); idle_inputs();

    // Load to odd address 0x41
    cyc();
    present_op(1, 0, 0, 32'h41, '0);
    smp();
    chk("mis_cap_stall", stall, 1);
    chk("mis_cap_req", mem_req, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    cyc(); smp();
    chk("mis_trap_req", mem_req, 0);
    chk("mis_trap_valid", out_valid, 1);
    chk("mis_trap_err", misalign_err, 1);
    chk("mis_trap_rw", out_reg_write, 0);
    chk("mis_trap_data", out_data, 0);
    chk("mis_trap_stall", stall, 0);
    cyc(); idle_inputs();
    smp();
    chk("mis_trap_err_clr", misalign_err, 0);
    chk("mis_trap_valid_clr", out_valid, 0);
`else
    load_beat(32'h40, 16'h0A0B, 0);
    load_beat(32'h42, 16'h0C0D, 1);
    cyc(); mem_rvalid = 0;
    smp();
    chk("mis_done_valid", out_valid, 1);
    chk("mis_done_data", out_data, 48'h0000_0C0D_0A0B);
    chk("mis_done_rw", out_reg_write, 1);
    chk("mis_done_alu", out_aluRes, 32'h41);
    cyc(); idle_inputs();
    smp();
    chk("mis_after_valid", out_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
